sha_msg_schedule: RTL and testbench
===================================

// Module: sha_msg_schedule
// PURPOSE
// - SHA-256 message schedule: accepts one 512-bit padded block, streams W[0..63] (one word/cycle)
//   with round index, to feed the W input of the round stage directly downstream.
// - Sliding 16-word window; one new word W[t+16] generated per advance. Optional K-constant ROM
//   so the downstream round's K input is driven in lock-step with W.
// PARAMETERS
// - none (SHA-256 fixed: 32-bit words, 64 rounds, 16-word window)
// PORTS
// - clk        in   1    clock, all state on rising edge
// - rst_n      in   1    asynchronous active-low reset
// - start_i    in   1    load block_i and begin schedule (honoured only in IDLE)
// - block_i    in   512  padded block; word 0 = bits[511:480], word 15 = bits[31:0]
// - en_i       in   1    advance enable; 0 = stall in RUN (hold all state)
// - busy_o     out  1    1 while in RUN
// - w_valid_o  out  1    w_o/k_o/t_o valid this cycle (= RUN && en_i)
// - w_o        out  32   W[t]
// - k_o        out  32   K[t] (see CONFIGURATION)
// - t_o        out  6    round index t
// - last_o     out  1    1 with W[63] (w_valid_o && t_o==63)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, window regs 0, t counter 0; busy_o=0, w_valid_o=0,
//   last_o=0, w_o=0, k_o=0, t_o=0. Reset mid-RUN aborts; no further words until new start_i.
// - States: IDLE -> RUN on start_i=1 (window <= block_i words 0..15, t <= 0);
//   RUN -> IDLE on edge where en_i=1 and t==63; otherwise RUN holds.
// - Latency: start_i sampled at edge N -> busy_o=1 and W[0] presented from cycle after N.
// - w_o = win[0] (register output, no comb path from inputs). t_o = t counter register.
// - Advance (RUN && en_i): win[i] <= win[i+1] for i=0..14; win[15] <= new; t <= t+1.
//   new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32 (carries dropped).
//   sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
// - For t>=48 the generated words are unused but computing them is harmless; t counter wraps
//   63->0 only on the RUN->IDLE edge.
// - Stall: en_i=0 in RUN -> w_valid_o=0, window/t/outputs held; stall of any length allowed,
//   including with t==63 (last_o stays 0 until en_i returns).
// - start_i while RUN: ignored, block_i not sampled. start_i on the same edge as RUN->IDLE:
//   ignored (IDLE must be observed >=1 cycle; busy_o drops for >=1 cycle between blocks).
// - In IDLE: w_valid_o=0, last_o=0, w_o/t_o hold last values (don't-care downstream).
// - Exactly 64 valid words per accepted start_i, in order t=0..63, no gaps except en_i stalls.
// CONFIGURATION
// - SHA_MSG_KROM_EN defined: internal 64x32 constant ROM (FIPS 180-4 K table) indexed by
//   the t counter; k_o = K[t_o] whenever w_valid_o=1, aligned same cycle as w_o.
// - SHA_MSG_KROM_EN undefined: no ROM instantiated; k_o tied to 32'h0; K supplied externally.
// TESTING
// - All-zero block, en_i=1: 64 valid cycles, w_o=0 every t, last_o only at t=63, busy_o
//   falls next cycle.
// - "abc" block (w0=0x61626380, w1..w14=0, w15=0x00000018): W[0]=0x61626380,
//   W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000; all 64 match reference model.
// - With SHA_MSG_KROM_EN: k_o=0x428A2F98 at t=0, 0xC67178F2 at t=63; without: k_o=0 always.
// - Random en_i stalls (~30% low) on random block: valid-word sequence identical to no-stall
//   run; t_o strictly increments on valid cycles; stall at t=63 delays last_o.
// - start_i pulsed at t=10 of a run and on the RUN->IDLE edge: ignored; output unchanged;
//   following start_i in IDLE accepted.
// - rst_n asserted async at t=30: all outputs 0 immediately; after release, no w_valid_o until
//   new start_i, which then yields W[0] of the new block.

Source files
------------

// File: rtl/sha_msg_schedule.sv
//-----------------------------------------------------------------------------
// Module      : sha_msg_schedule
// Description : SHA-256 message schedule. Loads one padded 512-bit block and
//               streams W[0..63], one word per advance, with the round index.
//               A sliding 16-word window produces W[t+16] on every advance.
//
// Ports       : clk        - clock, all state on rising edge
//               rst_n      - asynchronous active-low reset
//               start_i    - load block_i and start (honoured only in IDLE)
//               block_i    - padded block, word 0 = bits[511:480]
//               en_i       - advance enable, 0 stalls in RUN
//               busy_o     - high while in RUN
//               w_valid_o  - w_o/k_o/t_o valid this cycle
//               w_o        - W[t]
//               k_o        - K[t] (internal ROM) or 0
//               t_o        - round index t
//               last_o     - high with W[63]
//
// Build macro : SHA_MSG_KROM_EN - when defined, an internal K constant ROM
//               drives k_o in lock-step with w_o; otherwise k_o is tied to 0.
//
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module sha_msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [511:0] block_i,
    input  logic         en_i,
    output logic         busy_o,
    output logic         w_valid_o,
    output logic [31:0]  w_o,
    output logic [31:0]  k_o,
    output logic [5:0]   t_o,
    output logic         last_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [31:0] win [16];
    logic [5:0]  t_cnt;
    logic [31:0] new_word;
    logic        advance;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign advance = (state == RUN) && en_i;

    // win[i] holds W[t+i], so the recurrence for W[t+16] reads taps 14, 9, 1, 0.
    assign new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t_cnt <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                        t_cnt <= 6'd0;
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= block_i[511 - 32*i -: 32];
                        end
                    end
                end
                RUN: begin
                    if (en_i) begin
                        // Natural 6-bit wrap returns t to 0 exactly on the exit edge.
                        t_cnt <= t_cnt + 6'd1;
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= new_word;
                        if (t_cnt == 6'd63) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state == RUN);
    assign w_valid_o = advance;
    assign w_o       = win[0];
    assign t_o       = t_cnt;
    assign last_o    = advance && (t_cnt == 6'd63);

`ifdef SHA_MSG_KROM_EN
    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Gated by RUN so k_o reads 0 in reset/IDLE like the other outputs.
    assign k_o = busy_o ? K_TABLE[t_cnt] : 32'h0;
`else
    assign k_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sha_msg_schedule.sv
//-----------------------------------------------------------------------------
// Module      : tb_sha_msg_schedule
// Description : Self-checking bench for sha_msg_schedule. The expected W
//               sequence comes from the plain 64-entry SHA-256 recurrence.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_sha_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [511:0] block_i;
    logic         en_i;
    logic         busy_o;
    logic         w_valid_o;
    logic [31:0]  w_o;
    logic [31:0]  k_o;
    logic [5:0]   t_o;
    logic         last_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w [64];
    int          exp_idx = 0;

    sha_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .block_i   (block_i),
        .en_i      (en_i),
        .busy_o    (busy_o),
        .w_valid_o (w_valid_o),
        .w_o       (w_o),
        .k_o       (k_o),
        .t_o       (t_o),
        .last_o    (last_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: the full 64-word schedule straight from the textbook recurrence.
    task automatic build_model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[511 - 32*t -: 32];
            end else begin
                s0 = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk(w_valid_o == (busy_o && en_i), "valid_rule", {63'd0, w_valid_o}, {63'd0, busy_o && en_i});
            if (w_valid_o) begin
                if (exp_idx < 64) begin
                    chk(w_o == exp_w[exp_idx], "w_word", {32'd0, w_o}, {32'd0, exp_w[exp_idx]});
                    chk(t_o == exp_idx[5:0], "t_index", {58'd0, t_o}, 64'(exp_idx));
                    chk(last_o == (exp_idx == 63), "last_flag", {63'd0, last_o}, {63'd0, exp_idx == 63});
`ifdef SHA_MSG_KROM_EN
                    if (exp_idx == 0)  chk(k_o == 32'h428a2f98, "k_t0", {32'd0, k_o}, 64'h428a2f98);
                    if (exp_idx == 63) chk(k_o == 32'hc67178f2, "k_t63", {32'd0, k_o}, 64'hc67178f2);
`endif
                end else begin
                    chk(1'b0, "extra_word", 64'(exp_idx), 64'd63);
                end
                exp_idx++;
            end else begin
                chk(last_o == 1'b0, "last_idle", {63'd0, last_o}, 64'd0);
                if (busy_o && exp_idx < 64)
                    chk(w_o == exp_w[exp_idx], "stall_hold", {32'd0, w_o}, {32'd0, exp_w[exp_idx]});
            end
`ifndef SHA_MSG_KROM_EN
            chk(k_o == 32'h0, "k_zero", {32'd0, k_o}, 64'd0);
`endif
            if (!busy_o) exp_idx = 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(busy_o == 1'b0,    {tag, "_busy"},  {63'd0, busy_o},    64'd0);
        chk(w_valid_o == 1'b0, {tag, "_valid"}, {63'd0, w_valid_o}, 64'd0);
        chk(last_o == 1'b0,    {tag, "_last"},  {63'd0, last_o},    64'd0);
        chk(w_o == 32'h0,      {tag, "_w"},     {32'd0, w_o},       64'd0);
        chk(k_o == 32'h0,      {tag, "_k"},     {32'd0, k_o},       64'd0);
        chk(t_o == 6'd0,       {tag, "_t"},     {58'd0, t_o},       64'd0);
    endtask

    // One block: stall_pct = chance en_i low, stall63 = forced stalls at t=63,
    // inject = pulse start_i at t=10 and on the exit edge, abort_t = async reset at that t.
    task automatic run_block(input logic [511:0] blk, input int stall_pct, input int stall63,
                             input bit inject, input int abort_t);
        int cycles;
        int s63;
        bit done;
        bit en;
        build_model(blk);
        s63 = stall63;
        @(posedge clk); #1;
        block_i = blk;
        start_i = 1'b1;
        en_i    = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        block_i = rand_block();
        chk(busy_o == 1'b1, "busy_after_start", {63'd0, busy_o}, 64'd1);
        chk(w_o == exp_w[0], "w0_latency", {32'd0, w_o}, {32'd0, exp_w[0]});
        chk(t_o == 6'd0, "t_start", {58'd0, t_o}, 64'd0);
        cycles = 0;
        done   = 1'b0;
        while (!done) begin
            en = ($urandom_range(99) >= stall_pct);
            if (t_o == 6'd63 && s63 > 0) begin
                en = 1'b0;
                s63--;
            end
            start_i = 1'b0;
            if (inject && en && t_o == 6'd10) begin
                start_i = 1'b1;
                block_i = rand_block();
            end
            if (inject && en && t_o == 6'd63) start_i = 1'b1;
            if (abort_t >= 0 && t_o == abort_t[5:0]) begin
                rst_n = 1'b0;
                en_i  = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    chk(w_valid_o == 1'b0, "no_valid_after_abort", {63'd0, w_valid_o}, 64'd0);
                    chk(busy_o == 1'b0, "idle_after_abort", {63'd0, busy_o}, 64'd0);
                end
                en_i = 1'b0;
                return;
            end
            en_i = en;
            @(posedge clk); #1;
            cycles++;
            if (!busy_o) done = 1'b1;
            if (cycles > 2000) begin
                chk(1'b0, "run_timeout", 64'(cycles), 64'd64);
                done = 1'b1;
            end
        end
        start_i = 1'b0;
        chk(exp_idx == 64, "word_count", 64'(exp_idx), 64'd64);
        if (stall_pct == 0 && stall63 == 0)
            chk(cycles == 64, "run_length", 64'(cycles), 64'd64);
        @(posedge clk); #1;
        chk(busy_o == 1'b0, "idle_gap", {63'd0, busy_o}, 64'd0);
        en_i = 1'b0;
    endtask

    initial begin
        logic [511:0] abc;
        rst_n   = 1'b0;
        start_i = 1'b0;
        en_i    = 1'b0;
        block_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_block('0, 0, 0, 1'b0, -1);

        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        build_model(abc);
        chk(exp_w[16] == 32'h61626380, "model_w16", {32'd0, exp_w[16]}, 64'h61626380);
        chk(exp_w[17] == 32'h000f0000, "model_w17", {32'd0, exp_w[17]}, 64'h000f0000);
        chk(exp_w[15] == 32'h00000018, "model_w15", {32'd0, exp_w[15]}, 64'h00000018);
        run_block(abc, 0, 0, 1'b0, -1);

        run_block(rand_block(), 30, 3, 1'b0, -1);
        run_block(rand_block(), 0, 0, 1'b1, -1);
        run_block(rand_block(), 20, 0, 1'b0, 30);
        run_block(rand_block(), 20, 2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
